// File: rtl/tetris_pkg.sv
// Shared types for the LCD SPI capture path.
package tetris_pkg;

   localparam int LCD_BYTE_W = 9;

   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } lcd_byte_t;

   typedef enum logic {MON_IDLE, MON_RECV} mon_state_t;

endpackage

// File: rtl/lcd_spi_monitor_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers.
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             wr_ok;
   logic             rd_ok;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // A write into a full FIFO is accepted when the same cycle frees the head slot.
   assign wr_ok = wr_en && (!full || rd_en);
   assign rd_ok = rd_en && !empty;
   // Head is forced to zero while empty so the output has a defined reset value.
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer update; reads and writes are independent.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage array, written only on accepted pushes.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/lcd_spi_monitor.sv
// Passive SPI (mode 0, MSB first) snooper for the LCD link; queues {rs, byte}.
import tetris_pkg::*;

module lcd_spi_monitor #(
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  spi_sclk,
   input  logic                  spi_mosi,
   input  logic                  spi_ss_n,
   input  logic                  lcd_rs,
   input  logic                  rd_en,
   output logic [LCD_BYTE_W-1:0] rd_data,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   output logic                  frame_err,
   output logic [15:0]           byte_count
);

   logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync, rs_sync;
   logic       sclk_s, mosi_s, ss_s, rs_s;
   logic       sclk_dly_p1;
   logic       sclk_rise;
   mon_state_t state, state_next;
   logic       shift_en, clr_cnt, abort;
   logic       byte_done;
   logic [2:0] bit_cnt;
   // Only seven bits are held; the eighth comes straight from mosi on the push.
   logic [6:0] sreg;
   logic       push_p1;
   lcd_byte_t  push_data_p1;
   logic [15:0] byte_cnt_q;

   // Input synchronisers; ss_n resets to its idle (high) level.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_sync   <= '1;
         rs_sync   <= '0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
         rs_sync   <= {rs_sync[SYNC_STAGES-2:0], lcd_rs};
      end
   end

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign ss_s   = ss_sync[SYNC_STAGES-1];
   assign rs_s   = rs_sync[SYNC_STAGES-1];

   // Delayed copy of synced sclk for rising-edge detection.
   always_ff @(posedge clk) begin
      if (reset) sclk_dly_p1 <= 1'b0;
      else       sclk_dly_p1 <= sclk_s;
   end

   assign sclk_rise = sclk_s & ~sclk_dly_p1;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= MON_IDLE;
      else       state <= state_next;
   end

   // Next state and per-cycle controls; ss_n rising beats a coincident sclk edge.
   always_comb begin
      state_next = state;
      shift_en   = 1'b0;
      clr_cnt    = 1'b0;
      abort      = 1'b0;
      case (state)
         MON_IDLE: begin
            clr_cnt = 1'b1;
            if (!ss_s) state_next = MON_RECV;
         end
         MON_RECV: begin
            if (ss_s) begin
               state_next = MON_IDLE;
               abort      = (bit_cnt != 3'd0);
            end else if (sclk_rise) begin
               shift_en = 1'b1;
            end
         end
         default: state_next = MON_IDLE;
      endcase
   end

   assign byte_done = shift_en && (bit_cnt == 3'd7);

   // Bit counter, shift register, push strobe and frame error pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt   <= 3'd0;
         sreg      <= '0;
         push_p1   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (clr_cnt)       bit_cnt <= 3'd0;
         else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
         if (shift_en) sreg <= {sreg[5:0], mosi_s};
         push_p1   <= byte_done;
         frame_err <= abort;
      end
   end

   // Captured byte staged for the FIFO write one cycle after the 8th edge.
   always_ff @(posedge clk) begin
      if (byte_done) push_data_p1 <= '{rs: rs_s, data: {sreg, mosi_s}};
   end

   // Byte counter counts every completed byte, dropped or not.
   always_ff @(posedge clk) begin
      if (reset)          byte_cnt_q <= 16'd0;
      else if (byte_done) byte_cnt_q <= byte_cnt_q + 16'd1;
   end

   // Sticky overflow: push into a full FIFO with no simultaneous pop.
   always_ff @(posedge clk) begin
      if (reset)                           overflow <= 1'b0;
      else if (push_p1 && full && !rd_en) overflow <= 1'b1;
   end

   assign byte_count = byte_cnt_q;

   sync_fifo #(
      .WIDTH (LCD_BYTE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push_p1),
      .wr_data (push_data_p1),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .empty   (empty),
      .full    (full)
   );

endmodule

// File: tb/tb_lcd_spi_monitor.sv
// Directed plus randomized bench for lcd_spi_monitor with a queue-based reference model.
module tb_lcd_spi_monitor;

   localparam int DEPTH = 16;
   localparam int SS    = 2;

   logic        clk = 1'b0;
   logic        reset, sclk, mosi, ss_n, rs, rd_en;
   logic [8:0]  rd_data;
   logic        empty, full, overflow, frame_err;
   logic [15:0] byte_count;

   int          tests = 0;
   int          fails = 0;
   int          fe_cnt = 0;
   int          half = 4;
   logic [8:0]  q[$];
   logic [15:0] model_bc;
   logic        model_ovf;

   lcd_spi_monitor #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
      .clk        (clk),
      .reset      (reset),
      .spi_sclk   (sclk),
      .spi_mosi   (mosi),
      .spi_ss_n   (ss_n),
      .lcd_rs     (rs),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .empty      (empty),
      .full       (full),
      .overflow   (overflow),
      .frame_err  (frame_err),
      .byte_count (byte_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

   initial begin
      #5ms;
      $display("FAIL timeout tests=%0d", tests);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_push(input logic r, input logic [7:0] d);
      model_bc = model_bc + 16'd1;
      if (q.size() >= DEPTH) model_ovf = 1'b1;
      else                   q.push_back({r, d});
   endtask

   task automatic send_bits(input logic [7:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         mosi = d[7-i];
         wait_clk(half);
         sclk = 1'b1;
         wait_clk(half);
         sclk = 1'b0;
      end
   endtask

   task automatic send_byte(input logic r, input logic [7:0] d);
      rs = r;
      send_bits(d, 8);
      model_push(r, d);
   endtask

   task automatic begin_frame();
      ss_n = 1'b0;
      wait_clk(4);
   endtask

   task automatic end_frame();
      wait_clk(4);
      ss_n = 1'b1;
      wait_clk(8);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wait_clk(3);
      reset = 1'b0;
      q.delete();
      model_bc  = 16'd0;
      model_ovf = 1'b0;
      fe_cnt    = 0;
      wait_clk(1);
   endtask

   task automatic check_state(input string tag);
      check({tag, "_empty"}, empty, q.size() == 0);
      check({tag, "_full"}, full, q.size() == DEPTH);
      check({tag, "_ovf"}, overflow, model_ovf);
      check({tag, "_bc"}, byte_count, model_bc);
      check({tag, "_head"}, rd_data, (q.size() != 0) ? q[0] : 9'h000);
   endtask

   task automatic pop_check(input string tag);
      if (q.size() == 0) check({tag, "_empty"}, empty, 1'b1);
      else               check(tag, rd_data, q[0]);
      rd_en = 1'b1;
      wait_clk(1);
      rd_en = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
   endtask

   initial begin
      logic [7:0] d;
      logic       r;
      bit         found;
      int         k;
      int         fe0;

      reset = 1'b1; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1; rs = 1'b0; rd_en = 1'b0;
      model_bc = 16'd0; model_ovf = 1'b0;
      wait_clk(3);
      reset = 1'b0;
      wait_clk(1);

      // Reset state
      check("rst_rd_data", rd_data, 9'h000);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_byte_count", byte_count, 16'h0000);

      // 1: single command byte with latency measurement
      begin_frame();
      rs = 1'b0;
      send_bits(8'h2A, 7);
      mosi = 1'b0;
      wait_clk(half);
      sclk = 1'b1;
      found = 1'b0;
      k = 0;
      while (!found && k < SS + 3) begin
         @(posedge clk); #1;
         k++;
         if (empty === 1'b0) found = 1'b1;
      end
      check("t1_latency", found, 1'b1);
      wait_clk(half);
      sclk = 1'b0;
      model_push(1'b0, 8'h2A);
      end_frame();
      check("t1_rd_data", rd_data, 9'h02A);
      check("t1_byte_count", byte_count, 16'd1);
      pop_check("t1_pop");
      check("t1_empty_after", empty, 1'b1);

      // 2: multi-byte data frame
      do_reset();
      begin_frame();
      send_byte(1'b1, 8'h12);
      send_byte(1'b1, 8'h34);
      send_byte(1'b1, 8'h56);
      end_frame();
      check("t2_head", rd_data, 9'h112);
      pop_check("t2_pop0");
      pop_check("t2_pop1");
      check("t2_last", rd_data, 9'h156);
      pop_check("t2_pop2");
      check("t2_empty", empty, 1'b1);
      check("t2_no_frame_err", fe_cnt, 0);

      // 3: aborted frame followed by a good byte
      do_reset();
      begin_frame();
      send_bits(8'hF0, 5);
      end_frame();
      begin_frame();
      send_byte(1'b0, 8'hA5);
      end_frame();
      check("t3_frame_err_once", fe_cnt, 1);
      check("t3_byte_count", byte_count, 16'd1);
      check("t3_head", rd_data, 9'h0A5);
      pop_check("t3_pop");
      check("t3_only_one", empty, 1'b1);

      // 4: overflow with 17 bytes, no pops
      do_reset();
      begin_frame();
      for (int i = 0; i < 16; i++) begin
         send_byte(1'(i & 1), 8'(8'h40 + i));
         wait_clk(2);
         if (i == 14) check("t4_not_full_15", full, 1'b0);
      end
      check("t4_full_16", full, 1'b1);
      check("t4_no_ovf_16", overflow, 1'b0);
      send_byte(1'b1, 8'hEE);
      wait_clk(2);
      check("t4_ovf_17", overflow, 1'b1);
      check("t4_bc_17", byte_count, 16'd17);
      end_frame();
      for (int i = 0; i < 16; i++) pop_check("t4_drain");
      check("t4_empty", empty, 1'b1);
      check("t4_ovf_sticky", overflow, 1'b1);

      // 5: push and pop in the same cycle while full
      do_reset();
      begin_frame();
      for (int i = 0; i < 16; i++) send_byte(1'($urandom_range(0, 1)), 8'($urandom));
      wait_clk(2);
      check("t5_full_before", full, 1'b1);
      d = 8'($urandom);
      rs = 1'b1;
      send_bits(d, 7);
      mosi = d[0];
      wait_clk(half);
      sclk = 1'b1;
      wait_clk(3);
      check("t5_oldest", rd_data, q[0]);
      rd_en = 1'b1;
      wait_clk(1);
      rd_en = 1'b0;
      void'(q.pop_front());
      q.push_back({1'b1, d});
      model_bc = model_bc + 16'd1;
      wait_clk(half - 3);
      sclk = 1'b0;
      end_frame();
      check("t5_full_after", full, 1'b1);
      check("t5_no_ovf", overflow, 1'b0);
      check_state("t5");
      for (int i = 0; i < 16; i++) pop_check("t5_drain");
      check("t5_empty", empty, 1'b1);

      // 6: reset mid-byte, then one byte, then byte_count wrap
      do_reset();
      begin_frame();
      send_bits(8'hC3, 4);
      reset = 1'b1;
      wait_clk(2);
      reset = 1'b0;
      q.delete();
      model_bc = 16'd0;
      model_ovf = 1'b0;
      wait_clk(1);
      check("t6_rst_rd_data", rd_data, 9'h000);
      check("t6_rst_empty", empty, 1'b1);
      check("t6_rst_full", full, 1'b0);
      check("t6_rst_ovf", overflow, 1'b0);
      check("t6_rst_fe", frame_err, 1'b0);
      check("t6_rst_bc", byte_count, 16'h0000);
      wait_clk(4);
      send_byte(1'b1, 8'h5C);
      end_frame();
      check_state("t6_one");
      check("t6_no_fe", fe_cnt, 0);
      pop_check("t6_pop");
      force dut.byte_cnt_q = 16'hFFFF;
      wait_clk(1);
      release dut.byte_cnt_q;
      model_bc = 16'hFFFF;
      begin_frame();
      send_byte(1'b0, 8'h81);
      end_frame();
      check("t6_wrap", byte_count, 16'h0000);
      check_state("t6_wrap");
      pop_check("t6_wrap_pop");

      // Random frames and pops against the queue model
      do_reset();
      for (int f = 0; f < 24; f++) begin
         half = int'($urandom_range(2, 6));
         begin_frame();
         for (int b = 0, n = int'($urandom_range(1, 3)); b < n; b++) begin
            r = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            send_byte(r, d);
         end
         end_frame();
         check_state("rnd");
         for (int p = 0, n = int'($urandom_range(0, 3)); p < n; p++) pop_check("rnd_pop");
      end
      while (q.size() != 0) pop_check("rnd_drain");
      check_state("rnd_end");
      check("rnd_no_fe", fe_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
